// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core,
// with memory handshakes, request timeouts, halt/fault stops and perf counters.
module npc_ctrl_fsm #(
   parameter int OPCODE_W = 7,
   parameter int TIMEOUT  = 255,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [OPCODE_W-1:0] opcode_i,
   output logic                imem_req_o,
   input  logic                imem_ack_i,
   output logic                dmem_req_o,
   output logic                dmem_we_o,
   input  logic                dmem_ack_i,
   output logic                ir_we_o,
   output logic                re1_o,
   output logic                re2_o,
   output logic                we_reg_o,
   output logic                opsrc_o,
   output logic [2:0]          immsel_o,
   output logic                pc_we_o,
   output logic                halt_o,
   output logic                fault_o,
   output logic [1:0]          fault_code_o,
   output logic [2:0]          state_o,
   output logic [CNT_W-1:0]    cycle_cnt_o,
   output logic [CNT_W-1:0]    instret_o
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_t;
   typedef struct packed {
      logic       legal;
      logic       re1;
      logic       re2;
      logic [2:0] imm;
      logic       opsrc;
      logic       mem;
      logic       st;
      logic       wb;
   } cls_t;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   state_t            r_state, w_next;
   cls_t              r_cls, w_dec, w_cls;
   logic [WAIT_W-1:0] r_wait;
   logic [1:0]        r_code, w_code;
   logic [CNT_W-1:0]  r_cyc, r_ret;
   logic              w_tmo, w_ctl, w_active, w_ebreak;

   always_comb begin
      w_dec = '0;
      case (opcode_i)
         7'b0110011: w_dec = {1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
         7'b0010011: w_dec = {1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
         7'b0000011: w_dec = {1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1};
         7'b0100011: w_dec = {1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0};
         7'b1100011: w_dec = {1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
         7'b1101111: w_dec = {1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1};
         7'b1100111: w_dec = {1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
         7'b0110111,
         7'b0010111: w_dec = {1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
         default:    w_dec = '0;
      endcase
   end

   // DECODE drives controls straight from the opcode; later states replay the latched class
   assign w_cls    = (r_state == DECODE) ? w_dec : r_cls;
   assign w_ctl    = r_state inside {DECODE, EXEC, MEM, WB};
   assign w_active = r_state inside {FETCH, DECODE, EXEC, MEM, WB};
   assign w_tmo    = r_wait == WAIT_W'(TIMEOUT - 1);
   assign w_ebreak = opcode_i == 7'b1110011;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_code = r_code;
      case (r_state)
         IDLE:   w_next = start ? FETCH : IDLE;
         FETCH: begin
            w_next = imem_ack_i ? DECODE : (w_tmo ? FAULT : FETCH);
            w_code = (!imem_ack_i && w_tmo) ? 2'b01 : r_code;
         end
         DECODE: begin
            w_next = w_ebreak ? HALT : (w_dec.legal ? EXEC : FAULT);
            w_code = (!w_ebreak && !w_dec.legal) ? 2'b10 : r_code;
         end
         EXEC:   w_next = r_cls.mem ? MEM : WB;
         MEM: begin
            w_next = dmem_ack_i ? WB : (w_tmo ? FAULT : MEM);
            w_code = (!dmem_ack_i && w_tmo) ? 2'b11 : r_code;
         end
         WB:     w_next = FETCH;
         default: w_next = r_state;
      endcase
   end

   // the wait counter restarts whenever the state changes, i.e. on entry to FETCH or MEM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cls  <= '0;
         r_code <= '0;
         r_wait <= '0;
         r_cyc  <= '0;
         r_ret  <= '0;
      end else begin
         r_cls  <= w_cls;
         r_code <= w_code;
         r_wait <= (w_next == r_state && r_state inside {FETCH, MEM}) ? r_wait + WAIT_W'(1) : '0;
         r_cyc  <= r_cyc + CNT_W'(w_active);
         r_ret  <= r_ret + CNT_W'(r_state == WB);
      end
   end

   always_comb begin
      imem_req_o   = r_state == FETCH;
      ir_we_o      = r_state == FETCH && imem_ack_i;
      dmem_req_o   = r_state == MEM;
      dmem_we_o    = r_state == MEM && r_cls.st;
      re1_o        = w_ctl && w_cls.re1;
      re2_o        = w_ctl && w_cls.re2;
      immsel_o     = w_ctl ? w_cls.imm : 3'd0;
      opsrc_o      = w_ctl && w_cls.opsrc;
      we_reg_o     = r_state == WB && r_cls.wb;
      pc_we_o      = r_state == WB;
      halt_o       = r_state == HALT;
      fault_o      = r_state == FAULT;
      fault_code_o = r_code;
      state_o      = r_state;
      cycle_cnt_o  = r_cyc;
      instret_o    = r_ret;
   end
endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// tb_npc_ctrl_fsm: randomized instruction streams checked cycle by cycle against
// a transaction-level model built from the instruction class table.
module tb_npc_ctrl_fsm;
   localparam int TIMEOUT = 255;
   localparam int CNT_W   = 32;
   logic             clk = 1'b0;
   logic             rst, start, imem_ack_i, dmem_ack_i;
   logic [6:0]       opcode_i;
   logic             imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, re1_o, re2_o;
   logic             we_reg_o, opsrc_o, pc_we_o, halt_o, fault_o;
   logic [2:0]       immsel_o, state_o;
   logic [1:0]       fault_code_o;
   logic [CNT_W-1:0] cycle_cnt_o, instret_o;
   int               n_chk = 0, n_err = 0;
   logic [2:0]       e_st, e_imm;
   logic             e_ireq, e_irwe, e_dreq, e_dwe, e_re1, e_re2, e_we, e_op, e_pc, e_halt, e_flt;
   logic [1:0]       e_code;
   logic [CNT_W-1:0] e_cyc, e_ret;
   bit               s;
   logic [6:0]       ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                                  7'b1100111, 7'b0110111, 7'b0010111, 7'b0000011, 7'b1110011, 7'b1111111};

   npc_ctrl_fsm #(.OPCODE_W(7), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode_i(opcode_i),
      .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i),
      .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
      .ir_we_o(ir_we_o), .re1_o(re1_o), .re2_o(re2_o), .we_reg_o(we_reg_o),
      .opsrc_o(opsrc_o), .immsel_o(immsel_o), .pc_we_o(pc_we_o), .halt_o(halt_o),
      .fault_o(fault_o), .fault_code_o(fault_code_o), .state_o(state_o),
      .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
      $fatal(1);
   end

   // {legal, re1, re2, immsel, opsrc, mem, store, wb}
   function automatic logic [9:0] cls(input logic [6:0] op);
      case (op)
         7'b0110011: return {1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
         7'b0010011: return {1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
         7'b0000011: return {1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1};
         7'b0100011: return {1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0};
         7'b1100011: return {1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
         7'b1101111: return {1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1};
         7'b1100111: return {1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
         7'b0110111, 7'b0010111: return {1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
         default: return '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr(input logic [2:0] st);
      e_st = st;
      {e_ireq, e_irwe, e_dreq, e_dwe, e_re1, e_re2, e_we, e_op, e_pc, e_halt, e_flt} = '0;
      e_imm = 3'd0;
   endtask

   task automatic ctl(input logic [9:0] c);
      e_re1 = c[8];
      e_re2 = c[7];
      e_imm = c[6:4];
      e_op  = c[3];
   endtask

   task automatic check_outs(input string tag);
      #1;
      chk({tag, ":state"}, 64'(state_o), 64'(e_st));
      chk({tag, ":outs"},
          64'({imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, re1_o, re2_o, we_reg_o, opsrc_o, immsel_o, pc_we_o, halt_o, fault_o, fault_code_o}),
          64'({e_ireq, e_irwe, e_dreq, e_dwe, e_re1, e_re2, e_we, e_op, e_imm, e_pc, e_halt, e_flt, e_code}));
      chk({tag, ":cnt"}, {cycle_cnt_o, instret_o}, {e_cyc, e_ret});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_in();
      imem_ack_i = 1'($urandom);
      dmem_ack_i = 1'($urandom);
      opcode_i   = 7'($urandom);
      start      = 1'($urandom);
   endtask

   // HALT/FAULT must hold with inputs wiggling and counters frozen
   task automatic sticky(input logic [2:0] st);
      for (int k = 0; k < 4; k++) begin
         rand_in();
         clr(st);
         e_halt = st == 3'd6;
         e_flt  = st == 3'd7;
         check_outs(st == 3'd6 ? "halt" : "fault");
         tick();
      end
   endtask

   task automatic restart();
      rst = 1'b0;
      rand_in();
      clr(3'd0);
      e_cyc = '0; e_ret = '0; e_code = 2'd0;
      check_outs("reset");
      tick();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         rand_in();
         start = 1'b0;
         check_outs("idle");
         tick();
      end
      start = 1'b1;
      check_outs("idle_start");
      tick();
      start = 1'b0;
   endtask

   // fw/mw: request cycles without ack before the ack; >= TIMEOUT means never acked
   task automatic run_insn(input logic [6:0] op, input int fw, input int mw, input bit abort, output bit stop);
      logic [9:0] c;
      c = cls(op);
      stop = 1'b1;
      for (int k = 0; k < TIMEOUT; k++) begin
         rand_in();
         imem_ack_i = k == fw;
         clr(3'd1);
         e_ireq = 1'b1;
         e_irwe = k == fw;
         check_outs("fetch");
         tick();
         e_cyc++;
         if (k == fw) break;
      end
      if (fw >= TIMEOUT) begin
         e_code = 2'b01;
         sticky(3'd7);
         return;
      end
      rand_in();
      opcode_i = op;
      clr(3'd2);
      ctl(c);
      check_outs("decode");
      tick();
      e_cyc++;
      if (op == 7'b1110011) begin
         sticky(3'd6);
         return;
      end
      if (!c[9]) begin
         e_code = 2'b10;
         sticky(3'd7);
         return;
      end
      rand_in();
      clr(3'd3);
      ctl(c);
      check_outs("exec");
      tick();
      e_cyc++;
      if (c[2]) begin
         for (int k = 0; k < TIMEOUT; k++) begin
            rand_in();
            dmem_ack_i = k == mw;
            clr(3'd4);
            ctl(c);
            e_dreq = 1'b1;
            e_dwe  = c[1];
            check_outs("mem");
            if (abort) begin
               rst = 1'b0;
               clr(3'd0);
               e_cyc = '0; e_ret = '0; e_code = 2'd0;
               check_outs("rst_mid_mem");
               return;
            end
            tick();
            e_cyc++;
            if (k == mw) break;
         end
         if (mw >= TIMEOUT) begin
            e_code = 2'b11;
            sticky(3'd7);
            return;
         end
      end
      rand_in();
      clr(3'd5);
      ctl(c);
      e_we = c[0];
      e_pc = 1'b1;
      check_outs("wb");
      tick();
      e_cyc++;
      e_ret++;
      stop = 1'b0;
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; opcode_i = '0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
      clr(3'd0);
      e_cyc = '0; e_ret = '0; e_code = 2'd0;
      #2 check_outs("por");
      tick();
      rst = 1'b1;
      start = 1'b1;
      check_outs("idle_start");
      tick();
      run_insn(7'b0010011, 0, 0, 0, s);
      run_insn(7'b0100011, 0, 3, 0, s);
      run_insn(7'b0000011, 0, 0, 0, s);
      run_insn(7'b1100011, 0, 0, 0, s);
      run_insn(7'b0110011, TIMEOUT - 1, 0, 0, s);
      run_insn(7'b0000011, 0, TIMEOUT - 1, 0, s);
      run_insn(7'b0010011, TIMEOUT, 0, 0, s);
      restart();
      run_insn(7'b0000011, 0, TIMEOUT, 0, s);
      restart();
      run_insn(7'b0000000, 1, 0, 0, s);
      restart();
      run_insn(7'b1110011, 0, 0, 0, s);
      restart();
      run_insn(7'b0100011, 0, 2, 1, s);
      restart();
      for (int i = 0; i < 80; i++) begin
         int r;
         int fw;
         int mw;
         r  = $urandom_range(0, 39);
         fw = r == 0 ? TIMEOUT : (r == 1 ? TIMEOUT - 1 : int'($urandom_range(0, 3)));
         mw = r == 2 ? TIMEOUT : int'($urandom_range(0, 3));
         run_insn(ops[$urandom_range(0, 11)], fw, mw, r == 3, s);
         if (s) restart();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
